// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI master definitions: AXI response codes and FSM state encoding
//
// Imported by the SPI master transmit and receive blocks.
//   RESP_OKAY / RESP_SLVERR : AXI-lite response codes
//   spi_state_e             : RESET -> IDLE -> SHIFT -> RESP sequencing states

package spi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      IDLE  = 2'd1,
      SHIFT = 2'd2,
      RESP  = 2'd3
   } spi_state_e;

endpackage

// File: rtl/spi_master_recv.sv
// rtl/spi_master_recv.sv - AXI-lite read slave performing one MSB-first SPI receive per read
//
// Ports:
//   clk, resetn              : system clock, synchronous active-low reset
//   axi_lite_ar*             : read address channel (araddr, arvalid, arready)
//   axi_lite_r*              : read data channel (rdata, rresp, rvalid, rready)
//   spi_clk_recv_int         : one-clk sample strobe from the shared SPI clock generator
//   spi_miso                 : serial input data
//   spi_clk_dv               : enables the shared SPI clock generator during a transfer
//   spi_rx_busy              : high from address acceptance until the response is taken

module spi_master_recv
   import spi_pkg::*;
#(
   parameter int          DATA_BITS  = 8,
   parameter logic [31:0] RX_ADDR    = 32'h0000_0000,
   parameter bit          CHECK_ADDR = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] axi_lite_araddr,
   input  logic        axi_lite_arvalid,
   output logic        axi_lite_arready,
   output logic [31:0] axi_lite_rdata,
   output logic [1:0]  axi_lite_rresp,
   output logic        axi_lite_rvalid,
   input  logic        axi_lite_rready,
   input  logic        spi_clk_recv_int,
   input  logic        spi_miso,
   output logic        spi_clk_dv,
   output logic        spi_rx_busy
);

   // 5 bits covers a bit index of up to 31 (DATA_BITS <= 32)
   localparam int CNT_W = 5;

   spi_state_e           state_q, state_d;
   logic                 arready_q, arready_d;
   logic                 rvalid_q, rvalid_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [1:0]           rresp_q, rresp_d;
   logic                 dv_q, dv_d;
   logic                 busy_q, busy_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [DATA_BITS-1:0] shift_in;
   logic                 addr_ok;

   // Shift-left form stays legal for DATA_BITS == 1, where a part-select would not
   assign shift_in = (shift_q << 1) | DATA_BITS'(spi_miso);
   assign addr_ok  = !CHECK_ADDR || (axi_lite_araddr == RX_ADDR);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= RESET;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         dv_q      <= 1'b0;
         busy_q    <= 1'b0;
         shift_q   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         dv_q      <= dv_d;
         busy_q    <= busy_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      dv_d      = dv_q;
      busy_d    = busy_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;

      case (state_q)
         RESET: begin
            state_d   = IDLE;
            arready_d = 1'b1;
         end

         IDLE: begin
            if (axi_lite_arvalid && arready_q) begin
               arready_d = 1'b0;
               busy_d    = 1'b1;
               if (addr_ok) begin
                  state_d = SHIFT;
                  dv_d    = 1'b1;
                  shift_d = '0;
                  cnt_d   = CNT_W'(DATA_BITS - 1);
               end else begin
                  // Rejected address: answer immediately, SPI clock never started
                  state_d  = RESP;
                  rvalid_d = 1'b1;
                  rdata_d  = '0;
                  rresp_d  = RESP_SLVERR;
               end
            end
         end

         SHIFT: begin
            if (spi_clk_recv_int) begin
               shift_d = shift_in;
               if (cnt_q == '0) begin
                  // Last bit: publish the freshly shifted value on the same edge
                  state_d  = RESP;
                  dv_d     = 1'b0;
                  rdata_d  = 32'(shift_in);
                  rresp_d  = RESP_OKAY;
                  rvalid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end

         RESP: begin
            if (axi_lite_rready) begin
               state_d   = IDLE;
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               busy_d    = 1'b0;
            end
         end

         default: state_d = RESET;
      endcase
   end

   assign axi_lite_arready = arready_q;
   assign axi_lite_rvalid  = rvalid_q;
   assign axi_lite_rdata   = rdata_q;
   assign axi_lite_rresp   = rresp_q;
   assign spi_clk_dv       = dv_q;
   assign spi_rx_busy      = busy_q;

endmodule

// File: tb/tb_spi_master_recv.sv
// tb/tb_spi_master_recv.sv - self-checking bench for spi_master_recv

module tb_spi_master_recv;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        strobe;
   logic        miso;
   logic        dv;
   logic        busy;

   logic [31:0] b_araddr;
   logic        b_arvalid;
   logic        b_arready;
   logic [31:0] b_rdata;
   logic [1:0]  b_rresp;
   logic        b_rvalid;
   logic        b_rready;
   logic        b_strobe;
   logic        b_miso;
   logic        b_dv;
   logic        b_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_master_recv u_dut (
      .clk              (clk),
      .resetn           (resetn),
      .axi_lite_araddr  (araddr),
      .axi_lite_arvalid (arvalid),
      .axi_lite_arready (arready),
      .axi_lite_rdata   (rdata),
      .axi_lite_rresp   (rresp),
      .axi_lite_rvalid  (rvalid),
      .axi_lite_rready  (rready),
      .spi_clk_recv_int (strobe),
      .spi_miso         (miso),
      .spi_clk_dv       (dv),
      .spi_rx_busy      (busy)
   );

   spi_master_recv #(.DATA_BITS(1), .CHECK_ADDR(1'b0)) u_one (
      .clk              (clk),
      .resetn           (resetn),
      .axi_lite_araddr  (b_araddr),
      .axi_lite_arvalid (b_arvalid),
      .axi_lite_arready (b_arready),
      .axi_lite_rdata   (b_rdata),
      .axi_lite_rresp   (b_rresp),
      .axi_lite_rvalid  (b_rvalid),
      .axi_lite_rready  (b_rready),
      .spi_clk_recv_int (b_strobe),
      .spi_miso         (b_miso),
      .spi_clk_dv       (b_dv),
      .spi_rx_busy      (b_busy)
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  pat;
      int          gap;      // idle clks before each strobe; -1 = irregular (bit % 3)
      bit          stray;    // strobes in handshake cycle, RESP and IDLE
      int          hold;     // clks of rready=0 backpressure with arvalid held
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
   } vec_t;

   vec_t vecs[6];

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_read(input vec_t v, input string tag);
      bit bad;
      int dv_err;
      int hold_err;
      bad      = (v.exp_rresp == 2'b10);
      dv_err   = 0;
      hold_err = 0;

      araddr  = v.addr;
      arvalid = 1'b1;
      if (v.stray) begin
         strobe = 1'b1;
         miso   = 1'b1;
      end
      chk($sformatf("%s arready_idle", tag), arready, 1);
      tick;
      arvalid = 1'b0;
      strobe  = 1'b0;
      miso    = 1'b0;
      chk($sformatf("%s arready_after_hs", tag), arready, 0);
      chk($sformatf("%s busy_after_hs", tag), busy, 1);

      if (!bad) begin
         chk($sformatf("%s dv_after_hs", tag), dv, 1);
         for (int i = 7; i >= 0; i--) begin
            int g;
            g = (v.gap < 0) ? (i % 3) : v.gap;
            for (int k = 0; k < g; k++) begin
               if (dv !== 1'b1 || rvalid !== 1'b0) dv_err++;
               tick;
            end
            if (dv !== 1'b1 || rvalid !== 1'b0) dv_err++;
            strobe = 1'b1;
            miso   = v.pat[i];
            tick;
            strobe = 1'b0;
            miso   = 1'b0;
         end
         chk($sformatf("%s dv_rvalid_during_shift_errs", tag), dv_err, 0);
      end

      chk($sformatf("%s rvalid", tag), rvalid, 1);
      chk($sformatf("%s dv_in_resp", tag), dv, 0);
      chk($sformatf("%s rdata", tag), rdata, v.exp_rdata);
      chk($sformatf("%s rresp", tag), rresp, v.exp_rresp);

      if (v.stray) begin
         strobe = 1'b1;
         miso   = 1'b1;
         tick;
         strobe = 1'b0;
         miso   = 1'b0;
         chk($sformatf("%s rdata_after_resp_strobe", tag), rdata, v.exp_rdata);
      end

      for (int h = 0; h < v.hold; h++) begin
         arvalid = 1'b1;
         araddr  = 32'h0;
         tick;
         if (rvalid !== 1'b1 || rdata !== v.exp_rdata || rresp !== v.exp_rresp ||
             arready !== 1'b0 || dv !== 1'b0)
            hold_err++;
      end
      arvalid = 1'b0;
      if (v.hold > 0) chk($sformatf("%s backpressure_errs", tag), hold_err, 0);

      rready = 1'b1;
      tick;
      rready = 1'b0;
      chk($sformatf("%s rvalid_after_rready", tag), rvalid, 0);
      chk($sformatf("%s arready_after_rready", tag), arready, 1);
      chk($sformatf("%s busy_after_rready", tag), busy, 0);

      if (v.stray) begin
         strobe = 1'b1;
         miso   = 1'b1;
         tick;
         strobe = 1'b0;
         miso   = 1'b0;
         chk($sformatf("%s rdata_after_idle_strobe", tag), rdata, v.exp_rdata);
         chk($sformatf("%s rvalid_after_idle_strobe", tag), rvalid, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rv_err;

      vecs[0] = '{32'h0000_0000, 8'hA5,  3, 1'b0, 0, 32'h0000_00A5, 2'b00};
      vecs[1] = '{32'h0000_0000, 8'h3C, -1, 1'b1, 0, 32'h0000_003C, 2'b00};
      vecs[2] = '{32'h0000_0000, 8'h5A,  0, 1'b0, 5, 32'h0000_005A, 2'b00};
      vecs[3] = '{32'h0000_0010, 8'hFF,  0, 1'b0, 2, 32'h0000_0000, 2'b10};
      vecs[4] = '{32'h0000_0000, 8'h81,  1, 1'b1, 0, 32'h0000_0081, 2'b00};
      vecs[5] = '{32'hFFFF_FFFF, 8'h00,  0, 1'b0, 0, 32'h0000_0000, 2'b10};

      resetn    = 1'b0;
      araddr    = '0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      strobe    = 1'b0;
      miso      = 1'b0;
      b_araddr  = '0;
      b_arvalid = 1'b0;
      b_rready  = 1'b0;
      b_strobe  = 1'b0;
      b_miso    = 1'b0;

      tick;
      tick;
      tick;
      chk("reset arready", arready, 0);
      chk("reset rvalid", rvalid, 0);
      chk("reset rdata", rdata, 0);
      chk("reset rresp", rresp, 0);
      chk("reset dv", dv, 0);
      chk("reset busy", busy, 0);

      resetn = 1'b1;
      tick;
      chk("post_reset arready", arready, 1);
      chk("post_reset rvalid", rvalid, 0);

      for (int i = 0; i < 6; i++) run_read(vecs[i], $sformatf("vec%0d", i));

      // Abort mid-transfer: 4 of 8 bits, then reset
      araddr  = 32'h0;
      arvalid = 1'b1;
      tick;
      arvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         strobe = 1'b1;
         miso   = (i != 1);
         tick;
         strobe = 1'b0;
         miso   = 1'b0;
      end
      chk("abort dv_before_reset", dv, 1);
      resetn = 1'b0;
      tick;
      chk("abort arready", arready, 0);
      chk("abort rvalid", rvalid, 0);
      chk("abort rdata", rdata, 0);
      chk("abort rresp", rresp, 0);
      chk("abort dv", dv, 0);
      chk("abort busy", busy, 0);
      rv_err = 0;
      for (int i = 0; i < 2; i++) begin
         strobe = 1'b1;
         miso   = 1'b1;
         tick;
         if (rvalid !== 1'b0 || dv !== 1'b0) rv_err++;
      end
      strobe = 1'b0;
      miso   = 1'b0;
      resetn = 1'b1;
      tick;
      if (rvalid !== 1'b0) rv_err++;
      chk("abort no_response_errs", rv_err, 0);
      chk("abort arready_after_release", arready, 1);
      run_read('{32'h0000_0000, 8'hFF, 2, 1'b0, 0, 32'h0000_00FF, 2'b00}, "after_abort");

      // DATA_BITS=1, address check disabled: any address, single strobe completes
      b_araddr  = 32'h0000_0044;
      b_arvalid = 1'b1;
      chk("one arready_idle", b_arready, 1);
      tick;
      b_arvalid = 1'b0;
      chk("one dv_after_hs", b_dv, 1);
      chk("one busy_after_hs", b_busy, 1);
      b_strobe = 1'b1;
      b_miso   = 1'b1;
      tick;
      b_strobe = 1'b0;
      b_miso   = 1'b0;
      chk("one rvalid", b_rvalid, 1);
      chk("one rdata", b_rdata, 32'h1);
      chk("one rresp", b_rresp, 0);
      chk("one dv_in_resp", b_dv, 0);
      b_rready = 1'b1;
      tick;
      b_rready = 1'b0;
      chk("one rvalid_after_rready", b_rvalid, 0);
      chk("one arready_after_rready", b_arready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
